screen_buffer_clr_mem: RTL and testbench

- Parametrised dual-port screen buffer. Successor to the single-cycle-reset screen buffer.
- Port A: synchronous read-only display port, feeding the video scan-out.
- Port B: synchronous read/write port for the drawing logic.
- Replaces the combinational whole-array clear with a sequential clear/fill engine: one word per cycle, busy/done handshake, programmable fill value, write-drop reporting, and out-of-range address protection for non-power-of-two DEPTH.

---
 rtl/screen_buffer_clr_mem.sv | 147 ++++++++++++++
 tb/tb_screen_buffer_clr_mem.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/screen_buffer_clr_mem.sv
// screen_buffer_clr_mem
//   Dual-port screen buffer with a sequential clear/fill engine.
//   Port A is a registered read-only display port; port B is a registered
//   read-first read/write port for the drawing logic. The fill engine
//   writes one word per cycle and owns the write port while it runs.
//
// Ports
//   iClk        system clock, rising edge
//   iRst        synchronous active-low reset
//   iAddrA      port A read address
//   oDataA      port A read data (1-cycle latency, 0 when out of range)
//   iAddrB      port B address
//   iDataB      port B write data
//   iWeB        port B write enable
//   oDataB      port B read data (1-cycle latency, read-first, 0 when out of range)
//   iClrReq     fill request, honoured in IDLE only
//   iClrData    fill word, captured with an accepted request
//   oBusy       fill engine owns the memory
//   oClrDone    one-cycle pulse after the last word of a fill is written
//   oWrDropped  one-cycle pulse when an in-range port B write was discarded
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | port B writes allowed, waiting for a fill request
// S_CLEAR | writing fill word to mem[cnt], one word per cycle
// S_DONE  | single-cycle completion pulse, port B writes allowed

module screen_buffer_clr_mem #(
  parameter int              WIDTH       = 12,
  parameter int              DEPTH       = 600,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0,
  parameter int              AW          = $clog2(DEPTH)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [AW-1:0]    iAddrA,
  output logic [WIDTH-1:0] oDataA,
  input  logic [AW-1:0]    iAddrB,
  input  logic [WIDTH-1:0] iDataB,
  input  logic             iWeB,
  output logic [WIDTH-1:0] oDataB,
  input  logic             iClrReq,
  input  logic [WIDTH-1:0] iClrData,
  output logic             oBusy,
  output logic             oClrDone,
  output logic             oWrDropped
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // One extra bit so DEPTH itself is representable (DEPTH may equal 2**AW).
  localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] fill_q, fill_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] data_a_q, data_b_q;

  logic             a_in_range, b_in_range;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  assign a_in_range = ({1'b0, iAddrA} < DEPTH_X);
  assign b_in_range = ({1'b0, iAddrB} < DEPTH_X);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    drop_d  = 1'b0;
    we      = 1'b0;
    waddr   = iAddrB;
    wdata   = iDataB;
    case (state_q)
      S_IDLE: begin
        if (iClrReq) begin
          // The request wins the write port; a coincident port B write is lost.
          state_d = S_CLEAR;
          cnt_d   = '0;
          fill_d  = iClrData;
          drop_d  = iWeB && b_in_range;
        end else if (iWeB && b_in_range) begin
          we = 1'b1;
        end
      end
      S_CLEAR: begin
        we     = 1'b1;
        waddr  = cnt_q;
        wdata  = fill_q;
        drop_d = iWeB && b_in_range;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (iWeB && b_in_range) begin
          we = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_q  <= S_CLEAR;
      cnt_q    <= '0;
      fill_q   <= CLEAR_VALUE;
      drop_q   <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      drop_q   <= drop_d;
      data_a_q <= a_in_range ? mem[iAddrA] : '0;
      data_b_q <= b_in_range ? mem[iAddrB] : '0;
    end
  end

  // Storage is never reset; reset only freezes it.
  always_ff @(posedge iClk) begin
    if (iRst && we) begin
      mem[waddr] <= wdata;
    end
  end

  assign oDataA     = data_a_q;
  assign oDataB     = data_b_q;
  assign oBusy      = (state_q == S_CLEAR);
  assign oClrDone   = (state_q == S_DONE);
  assign oWrDropped = drop_q;

endmodule

// File: tb/tb_screen_buffer_clr_mem.sv
module tb_screen_buffer_clr_mem;

  localparam int W  = 12;
  localparam int D  = 600;
  localparam int AW = $clog2(D);

  logic          iClk = 1'b0;
  logic          iRst;
  logic [AW-1:0] iAddrA, iAddrB;
  logic [W-1:0]  iDataB, iClrData;
  logic          iWeB, iClrReq;
  logic [W-1:0]  oDataA, oDataB;
  logic          oBusy, oClrDone, oWrDropped;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  screen_buffer_clr_mem #(.WIDTH(W), .DEPTH(D), .CLEAR_VALUE('0)) dut (
    .iClk(iClk), .iRst(iRst),
    .iAddrA(iAddrA), .oDataA(oDataA),
    .iAddrB(iAddrB), .iDataB(iDataB), .iWeB(iWeB), .oDataB(oDataB),
    .iClrReq(iClrReq), .iClrData(iClrData),
    .oBusy(oBusy), .oClrDone(oClrDone), .oWrDropped(oWrDropped)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a fill is "words left to write"; memory is an array
  // with a known flag so never-written words are not compared.
  logic [W-1:0] m_mem [D];
  bit           m_known [D];
  int           m_left;
  bit           m_done;
  logic [W-1:0] m_fill;
  logic [W-1:0] exp_a, exp_b;
  bit           exp_a_k, exp_b_k, exp_drop;
  bit           m_req_ok, m_b_ok;
  int           m_a, m_b;

  always @(posedge iClk) begin
    if (!iRst) begin
      m_left  = D;
      m_fill  = '0;
      m_done  = 0;
      exp_a   = '0; exp_a_k = 1;
      exp_b   = '0; exp_b_k = 1;
      exp_drop = 0;
    end else begin
      m_a = int'(iAddrA);
      m_b = int'(iAddrB);
      if (m_a < D) begin exp_a = m_mem[m_a]; exp_a_k = m_known[m_a]; end
      else begin exp_a = '0; exp_a_k = 1; end
      if (m_b < D) begin exp_b = m_mem[m_b]; exp_b_k = m_known[m_b]; end
      else begin exp_b = '0; exp_b_k = 1; end
      m_b_ok   = iWeB && (m_b < D);
      m_req_ok = (m_left == 0) && !m_done && iClrReq;
      exp_drop = m_b_ok && ((m_left > 0) || m_req_ok);
      if (m_left > 0) begin
        m_mem[D - m_left]   = m_fill;
        m_known[D - m_left] = 1;
        m_left--;
        m_done = (m_left == 0);
      end else if (m_req_ok) begin
        m_left = D;
        m_fill = iClrData;
        m_done = 0;
      end else begin
        if (m_b_ok) begin
          m_mem[m_b]   = iDataB;
          m_known[m_b] = 1;
        end
        m_done = 0;
      end
    end
  end

  always @(negedge iClk) begin
    if (chk_en) begin
      check("m_busy", oBusy, (m_left > 0));
      check("m_done", oClrDone, m_done);
      check("m_drop", oWrDropped, exp_drop);
      if (exp_a_k) check("m_dataA", oDataA, exp_a);
      if (exp_b_k) check("m_dataB", oDataB, exp_b);
    end
  end

  task automatic wait_idle(output int n);
    n = 0;
    while (oBusy && n < 2000) begin
      n++;
      @(negedge iClk);
    end
    if (n >= 2000) check("busy_timeout", 32'd1, 32'd0);
  endtask

  int n;
  int rd_addrs [3] = '{0, 299, 599};

  initial begin
    iRst = 0; iAddrA = '0; iAddrB = '0; iDataB = '0; iWeB = 0;
    iClrReq = 0; iClrData = '0;
    @(negedge iClk);
    chk_en = 1;
    repeat (2) @(negedge iClk);
    check("rst_busy", oBusy, 1);
    check("rst_dataA", oDataA, 0);
    check("rst_dataB", oDataB, 0);
    check("rst_done", oClrDone, 0);
    check("rst_drop", oWrDropped, 0);

    // auto clear after release
    iRst = 1;
    wait_idle(n);
    check("autoclr_len", n, 600);
    check("autoclr_done", oClrDone, 1);
    foreach (rd_addrs[i]) begin
      iAddrA = AW'(rd_addrs[i]);
      @(negedge iClk);
      check("autoclr_rdA", oDataA, 0);
    end

    // port B write, read-first
    iAddrB = 10'd17; iDataB = 12'hABC; iWeB = 1;
    @(negedge iClk);
    check("rf_oldB", oDataB, 12'h000);
    check("wr_nodrop", oWrDropped, 0);
    iWeB = 0; iAddrA = 10'd17;
    @(negedge iClk);
    check("wr_rdA", oDataA, 12'hABC);
    check("wr_rdB", oDataB, 12'hABC);

    // fill with 0F0, write during CLEAR is dropped
    iClrReq = 1; iClrData = 12'h0F0;
    @(negedge iClk);
    iClrReq = 0;
    check("fill_busy", oBusy, 1);
    iWeB = 1; iAddrB = 10'd5; iDataB = 12'h123;
    @(negedge iClk);
    iWeB = 0;
    check("fill_drop", oWrDropped, 1);
    wait_idle(n);
    check("fill_done", oClrDone, 1);
    iAddrA = 10'd17; iAddrB = 10'd5;
    @(negedge iClk);
    check("fill_rdA17", oDataA, 12'h0F0);
    check("fill_rdB5", oDataB, 12'h0F0);

    // request and write collide
    iClrReq = 1; iClrData = 12'h3C3; iWeB = 1; iAddrB = 10'd3; iDataB = 12'h111;
    @(negedge iClk);
    iClrReq = 0; iWeB = 0;
    check("col_busy", oBusy, 1);
    check("col_drop", oWrDropped, 1);
    wait_idle(n);
    iAddrB = 10'd3;
    @(negedge iClk);
    check("col_rdB3", oDataB, 12'h3C3);

    // out-of-range write and read
    iAddrB = 10'd600; iDataB = 12'h555; iWeB = 1;
    @(negedge iClk);
    iWeB = 0;
    check("oor_nodrop", oWrDropped, 0);
    check("oor_rdB", oDataB, 0);
    iAddrA = 10'd599;
    @(negedge iClk);
    check("oor_rdA599", oDataA, 12'h3C3);

    // reset in the middle of a fill
    iClrReq = 1; iClrData = 12'hFFF;
    @(negedge iClk);
    iClrReq = 0;
    repeat (250) @(negedge iClk);
    iRst = 0;
    repeat (2) @(negedge iClk);
    check("mid_rst_busy", oBusy, 1);
    iRst = 1; iAddrA = 10'd249; iAddrB = 10'd250;
    @(negedge iClk);
    check("mid_rdA249", oDataA, 12'hFFF);
    check("mid_rdB250", oDataB, 12'h3C3);
    wait_idle(n);
    check("mid_restart_len", n, 599);
    check("mid_done", oClrDone, 1);
    iAddrA = 10'd249;
    @(negedge iClk);
    check("mid_rdA249_after", oDataA, 0);

    repeat (2) @(negedge iClk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
